// File: rtl/trdb_pkg.sv
// trdb_pkg: register map, CTRL bit positions and controller states for the trace controller
package trdb_pkg;
    localparam logic [4:0] OFF_CTRL       = 5'h00;
    localparam logic [4:0] OFF_STATUS     = 5'h04;
    localparam logic [4:0] OFF_START      = 5'h08;
    localparam logic [4:0] OFF_STOP       = 5'h0C;
    localparam logic [4:0] OFF_WORD_CNT   = 5'h10;
    localparam logic [4:0] OFF_WORD_LIMIT = 5'h14;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_FILTER  = 1;
    localparam int unsigned CTRL_CLR_CNT = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_TRACING = 2'd2,
        ST_DRAIN   = 2'd3
    } trdb_ctrl_state_t;
endpackage

// File: rtl/trdb_ctrl_regs.sv
// trdb_ctrl_regs: APB decode and register file of the trace controller
module trdb_ctrl_regs
    import trdb_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned APB_ADDR_WIDTH = 12
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
    input  logic [XLEN-1:0]           pwdata_i,
    input  logic                      pwrite_i,
    input  logic                      psel_i,
    input  logic                      penable_i,
    output logic [XLEN-1:0]           prdata_o,
    output logic                      pslverr_o,
    input  logic [1:0]                state_i,
    input  logic                      done_i,
    input  logic [XLEN-1:0]           word_cnt_i,
    input  logic                      hw_clr_en_i,
    output logic                      ctrl_we_o,
    output logic                      wr_en_o,
    output logic                      wr_filter_o,
    output logic                      clr_cnt_o,
    output logic                      filter_o,
    output logic [XLEN-1:0]           start_o,
    output logic [XLEN-1:0]           stop_o,
    output logic [XLEN-1:0]           limit_o
);
    logic [4:0]      off;
    logic            acc, wr, unused;
    logic            en_q, en_d, filter_q, filter_d;
    logic [XLEN-1:0] start_q, start_d, stop_q, stop_d, limit_q, limit_d, rdata;

    // only bits [4:2] select a register; the rest of the address is ignored
    assign off         = {paddr_i[4:2], 2'b00};
    assign unused      = ^{paddr_i[APB_ADDR_WIDTH-1:5], paddr_i[1:0]};
    assign acc         = psel_i & penable_i;
    assign wr          = acc & pwrite_i;
    assign ctrl_we_o   = wr & (off == OFF_CTRL);
    assign wr_en_o     = pwdata_i[CTRL_EN];
    assign wr_filter_o = pwdata_i[CTRL_FILTER];
    assign clr_cnt_o   = ctrl_we_o & pwdata_i[CTRL_CLR_CNT];
    assign filter_o    = filter_q;
    assign start_o     = start_q;
    assign stop_o      = stop_q;
    assign limit_o     = limit_q;
    assign pslverr_o   = acc & (off > OFF_WORD_LIMIT);
    assign prdata_o    = (acc & ~pwrite_i) ? rdata : '0;

    always_comb begin
        en_d     = hw_clr_en_i ? 1'b0 : ctrl_we_o ? wr_en_o : en_q;
        filter_d = ctrl_we_o ? wr_filter_o : filter_q;
        start_d  = (wr & (off == OFF_START)) ? pwdata_i : start_q;
        stop_d   = (wr & (off == OFF_STOP)) ? pwdata_i : stop_q;
        limit_d  = (wr & (off == OFF_WORD_LIMIT)) ? pwdata_i : limit_q;
        rdata    = '0;
        case (off)
            OFF_CTRL:       rdata = {{(XLEN-2){1'b0}}, filter_q, en_q};
            OFF_STATUS:     rdata = {{(XLEN-5){1'b0}}, done_i, 2'b00, state_i};
            OFF_START:      rdata = start_q;
            OFF_STOP:       rdata = stop_q;
            OFF_WORD_CNT:   rdata = word_cnt_i;
            OFF_WORD_LIMIT: rdata = limit_q;
            default:        rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q     <= 1'b0;
            filter_q <= 1'b0;
            start_q  <= '0;
            stop_q   <= '0;
            limit_q  <= '0;
        end else begin
            en_q     <= en_d;
            filter_q <= filter_d;
            start_q  <= start_d;
            stop_q   <= stop_d;
            limit_q  <= limit_d;
        end
    end
endmodule

// File: rtl/trdb_trace_ctrl.sv
// trdb_trace_ctrl: trace session sequencer (arm/qualify/flush) with packet word counter
module trdb_trace_ctrl
    import trdb_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned APB_ADDR_WIDTH = 12
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
    input  logic [XLEN-1:0]           pwdata_i,
    input  logic                      pwrite_i,
    input  logic                      psel_i,
    input  logic                      penable_i,
    output logic [XLEN-1:0]           prdata_o,
    output logic                      pready_o,
    output logic                      pslverr_o,
    input  logic                      ivalid_i,
    input  logic [XLEN-1:0]           iaddr_i,
    input  logic                      packet_word_valid_i,
    input  logic                      flush_done_i,
    output logic                      trace_enable_o,
    output logic                      qualified_o,
    output logic                      flush_o,
    output logic                      irq_o
);
    trdb_ctrl_state_t state_q, state_d;
    logic [XLEN-1:0]  cnt_q, cnt_d, start, stop, limit;
    logic [XLEN:0]    cnt_sum;
    logic             done_q, done_d, irq_q, irq_d;
    logic             ctrl_we, wr_en, wr_filter, clr_cnt, filter, hw_clr_en;
    logic             en_off, start_hit, stop_hit, limit_hit, active;

    trdb_ctrl_regs #(.XLEN(XLEN), .APB_ADDR_WIDTH(APB_ADDR_WIDTH)) u_regs (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .paddr_i     (paddr_i),
        .pwdata_i    (pwdata_i),
        .pwrite_i    (pwrite_i),
        .psel_i      (psel_i),
        .penable_i   (penable_i),
        .prdata_o    (prdata_o),
        .pslverr_o   (pslverr_o),
        .state_i     (state_q),
        .done_i      (done_q),
        .word_cnt_i  (cnt_q),
        .hw_clr_en_i (hw_clr_en),
        .ctrl_we_o   (ctrl_we),
        .wr_en_o     (wr_en),
        .wr_filter_o (wr_filter),
        .clr_cnt_o   (clr_cnt),
        .filter_o    (filter),
        .start_o     (start),
        .stop_o      (stop),
        .limit_o     (limit)
    );

    assign en_off    = ctrl_we & ~wr_en;
    assign start_hit = ivalid_i & (iaddr_i == start);
    assign stop_hit  = filter & ivalid_i & (iaddr_i == stop);
    // the word arriving this cycle already counts toward the budget
    assign cnt_sum   = {1'b0, cnt_q} + {{XLEN{1'b0}}, packet_word_valid_i};
    assign limit_hit = (limit != '0) & (cnt_sum >= {1'b0, limit});
    assign active    = (state_q == ST_TRACING) | (state_q == ST_DRAIN);
    assign hw_clr_en = (state_q == ST_TRACING) & (state_d == ST_DRAIN);

    assign pready_o       = 1'b1;
    assign trace_enable_o = active;
    assign flush_o        = state_q == ST_DRAIN;
    assign irq_o          = irq_q;
    assign qualified_o    = ivalid_i & ((state_q == ST_TRACING) | ((state_q == ST_ARMED) & (iaddr_i == start)));

    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        irq_d   = 1'b0;
        case (state_q)
            ST_IDLE: if (ctrl_we & wr_en) begin
                state_d = wr_filter ? ST_ARMED : ST_TRACING;
                done_d  = 1'b0;
            end
            ST_ARMED:   state_d = en_off ? ST_IDLE : start_hit ? ST_TRACING : ST_ARMED;
            ST_TRACING: state_d = (en_off | stop_hit | limit_hit) ? ST_DRAIN : ST_TRACING;
            default: if (flush_done_i) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                irq_d   = 1'b1;
            end
        endcase
        cnt_d = clr_cnt ? '0 : (active & packet_word_valid_i & ~&cnt_q) ? cnt_q + XLEN'(1) : cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            irq_q   <= irq_d;
        end
    end
endmodule

// File: doc/trdb_trace_ctrl.md
# trdb_trace_ctrl

APB-programmable controller that sequences the trace debugger datapath: it holds the trace configuration, arms and qualifies tracing on start/stop instruction addresses or a word budget, drives the flush handshake that drains the packet pipeline on stop, and counts emitted packet words. It sits between the SoC APB bus and the trace pipeline, replacing the hard-wired trace enable and qualification.

## Interface
- XLEN, 32: instruction address and APB data width
- APB_ADDR_WIDTH, 12: APB address width; bits [4:2] decode registers
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- paddr_i, pwdata_i, pwrite_i, psel_i, penable_i  in  APB_ADDR_WIDTH/XLEN/1/1/1  APB request
- prdata_o  out  XLEN  read data; 0 for unmapped addresses
- pready_o  out  1  constant 1 (zero wait states)
- pslverr_o  out  1  high during access phase to an unmapped offset
- ivalid_i  in  1  retired instruction valid
- iaddr_i  in  XLEN  retired instruction address
- packet_word_valid_i  in  1  one packet word emitted this cycle
- flush_done_i  in  1  pipeline empty after flush
- trace_enable_o  out  1  datapath enable
- qualified_o  out  1  current instruction is traced
- flush_o  out  1  flush request, level
- irq_o  out  1  one-cycle pulse when a trace session ends

## Operation
- Registers (offset): CTRL 0x00 RW: bit0 EN, bit1 FILTER, bit2 CLR_CNT (write-1 self-clearing, reads 0); STATUS 0x04 RO: [1:0] state, bit4 DONE (sticky); START 0x08 RW; STOP 0x0C RW; WORD_CNT 0x10 RO; WORD_LIMIT 0x14 RW (0 = unlimited).
- APB write commits when psel_i & penable_i & pwrite_i; unmapped writes are dropped with pslverr_o.
- FSM states IDLE(0), ARMED(1), TRACING(2), DRAIN(3).
- IDLE: a CTRL write with EN=1 moves to ARMED if FILTER=1, else TRACING; clears DONE.
- ARMED: ivalid_i & iaddr_i==START -> TRACING; that instruction is qualified.
- TRACING -> DRAIN on any of: CTRL write EN=0; FILTER & ivalid_i & iaddr_i==STOP (stop instruction qualified); WORD_LIMIT!=0 and WORD_CNT+packet_word_valid_i >= WORD_LIMIT. On entry HW clears EN.
- ARMED with EN write 0 -> IDLE directly, no flush, no irq.
- DRAIN: flush_o=1 until flush_done_i sampled high; then IDLE, DONE set, irq_o pulsed. EN writes during DRAIN are stored but do not restart; restart requires a new EN=1 write in IDLE.
- trace_enable_o = state in {TRACING, DRAIN}.
- qualified_o = (state==TRACING & ivalid_i) | (state==ARMED & ivalid_i & iaddr_i==START).
- WORD_CNT increments on packet_word_valid_i in TRACING or DRAIN, saturates at all-ones; CLR_CNT wins over a simultaneous increment.
- Register writes to START/STOP/WORD_LIMIT take effect the following cycle in any state.

## Timing
- Reset: state IDLE, all registers 0, trace_enable_o/qualified_o/flush_o/irq_o/pslverr_o/prdata_o 0, pready_o 1.
- qualified_o is combinational from ivalid_i/iaddr_i; all other outputs registered or state-decoded.
- Stop condition in cycle N -> flush_o high in N+1; flush_done_i high in cycle M -> state IDLE and irq_o high in M+1 for exactly one cycle.
- flush_done_i already high on DRAIN entry: DRAIN lasts one cycle.
- Reads return register value as of the access-phase cycle (no read side effects).
- Reset mid-DRAIN: flush_o drops immediately; no irq.

## Structure
- trdb_pkg: register offset constants, trdb_ctrl_state_t enum, CTRL bit index constants.
- Sub-module trdb_ctrl_regs: APB decode and register file; FSM and counter in trdb_trace_ctrl top.

## Test plan
- Write CTRL=0x1, 5 valid instrs, 3 packet words, write CTRL=0x0, flush_done_i after 4 cycles -> qualified_o high 5 cycles, flush_o high 4 cycles, irq_o 1 pulse, WORD_CNT=3, STATUS=0x10.
- START=0x100, STOP=0x120, CTRL=0x3, stream 0xF0..0x130 step 4 -> qualified_o exactly for 0x100..0x120 (9 instrs), then DRAIN.
- WORD_LIMIT=4, CTRL=0x1, continuous packet_word_valid_i -> DRAIN entered in cycle the 4th word is counted, WORD_CNT ends 4 plus words during DRAIN.
- CTRL=0x5 (CLR_CNT) with simultaneous packet word -> WORD_CNT reads 0; bit2 reads 0.
- Read offset 0x18 and write 0x1C -> pslverr_o=1, prdata_o=0, no register change.
- Assert rst_ni during DRAIN -> all outputs at reset values next edge, no irq_o.
